// File: rtl/frog_pkg.sv
// Shared state encoding and widths for the frog round/lives sequencer.
package frog_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_PLAY      = 3'd1,
    ST_DYING     = 3'd2,
    ST_RESPAWN   = 3'd3,
    ST_LEVEL_UP  = 3'd4,
    ST_GAME_OVER = 3'd5
  } round_state_t;

  localparam logic [3:0] MAX_SPEED = 4'd9;
  localparam int         LIVES_W   = 3;
  localparam int         TIMER_W   = 8;

endpackage

// File: rtl/frog_round_ctrl_tick_counter.sv
// Terminal-count counter advanced by frame ticks; o_wrap flags the tick that
// takes the count from TC-1 back to 0.
module tick_counter #(
  parameter int TC = 60
) (
  input  logic clk,
  input  logic srst,
  input  logic i_clear,
  input  logic i_tick,
  output logic o_wrap
);

  localparam int            W    = (TC > 1) ? $clog2(TC) : 1;
  localparam logic [W-1:0]  LAST = W'(TC - 1);

  logic [W-1:0] r_count;

  assign o_wrap = i_tick && !i_clear && (r_count == LAST);

  always_ff @(posedge clk) begin
    if (srst || i_clear) begin
      r_count <= '0;
    end else if (i_tick) begin
      r_count <= (r_count == LAST) ? '0 : r_count + W'(1);
    end
  end

endmodule

// File: rtl/frog_round_ctrl.sv
// Round/lives sequencer driving the frog movement block's reset, speed and gameOver.
// Define FROG_BONUS_LIFE_EN to award an extra life (capped at 7) on every level-up.
module frog_round_ctrl
  import frog_pkg::*;
#(
  parameter int LIVES_INIT    = 3,
  parameter int TICKS_PER_SEC = 60,
  parameter int ROUND_SECS    = 30,
  parameter int DEATH_TICKS   = 60,
  parameter int MAX_LEVEL     = int'(MAX_SPEED)
) (
  input  logic               clk,
  input  logic               Reset,
  input  logic               tick,
  input  logic               start,
  input  logic               collision,
  input  logic               home_event,
  input  logic               all_home,
  output logic               frog_reset,
  output logic               game_over,
  output logic [3:0]         speed,
  output logic [LIVES_W-1:0] lives,
  output logic [TIMER_W-1:0] timer,
  output logic [2:0]         state
);

  localparam logic [LIVES_W-1:0] LP_LIVES_INIT = LIVES_W'(LIVES_INIT);
  localparam logic [TIMER_W-1:0] LP_ROUND      = TIMER_W'(ROUND_SECS);
  localparam logic [3:0]         LP_MAX_LEVEL  = 4'(MAX_LEVEL);

  round_state_t       r_state;
  logic               r_frog_reset;
  logic               r_game_over;
  logic [3:0]         r_speed;
  logic [LIVES_W-1:0] r_lives;
  logic [TIMER_W-1:0] r_timer;

  logic               w_sec_tick;
  logic               w_sec_wrap;
  logic               w_death_wrap;
  logic [LIVES_W-1:0] w_lives_dec;

  // Seconds only advance on a tick that no higher-priority PLAY event pre-empts.
  assign w_sec_tick  = tick && (r_state == ST_PLAY) && !collision && !all_home && !home_event;
  assign w_lives_dec = (r_lives == '0) ? '0 : r_lives - LIVES_W'(1);

  tick_counter #(.TC(TICKS_PER_SEC)) u_sec_cnt (
    .clk     (clk),
    .srst    (Reset),
    .i_clear (r_state == ST_RESPAWN),
    .i_tick  (w_sec_tick),
    .o_wrap  (w_sec_wrap)
  );

  tick_counter #(.TC(DEATH_TICKS)) u_death_cnt (
    .clk     (clk),
    .srst    (Reset),
    .i_clear (r_state != ST_DYING),
    .i_tick  (tick && (r_state == ST_DYING)),
    .o_wrap  (w_death_wrap)
  );

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state      <= ST_IDLE;
      r_frog_reset <= 1'b0;
      r_game_over  <= 1'b0;
      r_speed      <= '0;
      r_lives      <= LP_LIVES_INIT;
      r_timer      <= LP_ROUND;
    end else begin
      r_frog_reset <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            r_state      <= ST_RESPAWN;
            r_frog_reset <= 1'b1;
            r_lives      <= LP_LIVES_INIT;
            r_speed      <= '0;
          end
        end
        ST_PLAY: begin
          if (collision) begin
            r_state <= ST_DYING;
            r_lives <= w_lives_dec;
          end else if (all_home) begin
            r_state <= ST_LEVEL_UP;
          end else if (home_event) begin
            r_state      <= ST_RESPAWN;
            r_frog_reset <= 1'b1;
            r_timer      <= LP_ROUND;
          end else if (w_sec_wrap) begin
            r_timer <= r_timer - TIMER_W'(1);
            if (r_timer == TIMER_W'(1)) begin
              r_state <= ST_DYING;
              r_lives <= w_lives_dec;
            end
          end
        end
        ST_DYING: begin
          if (w_death_wrap) begin
            if (r_lives == '0) begin
              r_state     <= ST_GAME_OVER;
              r_game_over <= 1'b1;
            end else begin
              r_state      <= ST_RESPAWN;
              r_frog_reset <= 1'b1;
            end
          end
        end
        ST_RESPAWN: begin
          r_state <= ST_PLAY;
          r_timer <= LP_ROUND;
        end
        ST_LEVEL_UP: begin
          r_state      <= ST_RESPAWN;
          r_frog_reset <= 1'b1;
          if (r_speed < LP_MAX_LEVEL) begin
            r_speed <= r_speed + 4'd1;
          end
`ifdef FROG_BONUS_LIFE_EN
          if (r_lives != '1) begin
            r_lives <= r_lives + LIVES_W'(1);
          end
`endif
        end
        ST_GAME_OVER: begin
          if (start) begin
            r_state     <= ST_IDLE;
            r_game_over <= 1'b0;
          end
        end
        default: begin
          r_state     <= ST_IDLE;
          r_game_over <= 1'b0;
        end
      endcase
    end
  end

  assign frog_reset = r_frog_reset;
  assign game_over  = r_game_over;
  assign speed      = r_speed;
  assign lives      = r_lives;
  assign timer      = r_timer;
  assign state      = r_state;

endmodule

// File: tb/tb_frog_round_ctrl.sv
// Directed bench for frog_round_ctrl: a tick-counting reference model checked every
// cycle, plus literal expectations at the key points of each scenario.
module tb_frog_round_ctrl;

  localparam int LIVES_INIT    = 3;
  localparam int TICKS_PER_SEC = 60;
  localparam int ROUND_SECS    = 30;
  localparam int DEATH_TICKS   = 60;
  localparam int MAX_LEVEL     = 9;

  logic       clk = 1'b0;
  logic       Reset = 1'b1;
  logic       tick = 1'b0;
  logic       start = 1'b0;
  logic       collision = 1'b0;
  logic       home_event = 1'b0;
  logic       all_home = 1'b0;
  logic       frog_reset;
  logic       game_over;
  logic [3:0] speed;
  logic [2:0] lives;
  logic [7:0] timer;
  logic [2:0] state;

  int n_checks = 0;
  int n_errors = 0;

  frog_round_ctrl #(
    .LIVES_INIT    (LIVES_INIT),
    .TICKS_PER_SEC (TICKS_PER_SEC),
    .ROUND_SECS    (ROUND_SECS),
    .DEATH_TICKS   (DEATH_TICKS),
    .MAX_LEVEL     (MAX_LEVEL)
  ) dut (
    .clk        (clk),
    .Reset      (Reset),
    .tick       (tick),
    .start      (start),
    .collision  (collision),
    .home_event (home_event),
    .all_home   (all_home),
    .frog_reset (frog_reset),
    .game_over  (game_over),
    .speed      (speed),
    .lives      (lives),
    .timer      (timer),
    .state      (state)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input int act, input int exp);
    n_checks++;
    if (act != exp) begin
      n_errors++;
      $display("FAIL %s actual=%0d required=%0d at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a life is measured in elapsed ticks, the timer is derived from it.
  int m_state = 0, m_lives = LIVES_INIT, m_speed = 0;
  int m_life_ticks = 0, m_death_ticks = 0;
  bit m_valid = 1'b0;

  function automatic void m_die();
    m_lives = (m_lives > 0) ? m_lives - 1 : 0;
    m_death_ticks = 0;
    m_state = 2;
  endfunction

  always @(posedge clk) begin
    if (Reset) begin
      m_valid = 1'b1;
      m_state = 0; m_lives = LIVES_INIT; m_speed = 0;
      m_life_ticks = 0; m_death_ticks = 0;
    end else begin
      case (m_state)
        0: if (start) begin m_state = 3; m_lives = LIVES_INIT; m_speed = 0; end
        1: begin
          if (collision) m_die();
          else if (all_home) m_state = 4;
          else if (home_event) begin m_state = 3; m_life_ticks = 0; end
          else if (tick) begin
            m_life_ticks++;
            if (m_life_ticks == ROUND_SECS * TICKS_PER_SEC) m_die();
          end
        end
        2: if (tick) begin
          m_death_ticks++;
          if (m_death_ticks == DEATH_TICKS) m_state = (m_lives == 0) ? 5 : 3;
        end
        3: begin m_life_ticks = 0; m_state = 1; end
        4: begin
          m_speed = (m_speed < MAX_LEVEL) ? m_speed + 1 : MAX_LEVEL;
`ifdef FROG_BONUS_LIFE_EN
          m_lives = (m_lives < 7) ? m_lives + 1 : 7;
`endif
          m_state = 3;
        end
        5: if (start) m_state = 0;
        default: m_state = 0;
      endcase
    end
  end

  always @(negedge clk) begin
    if (m_valid) begin
      check("model_state", int'(state), m_state);
      check("model_lives", int'(lives), m_lives);
      check("model_speed", int'(speed), m_speed);
      check("model_timer", int'(timer), ROUND_SECS - m_life_ticks / TICKS_PER_SEC);
      check("model_frog_reset", int'(frog_reset), (m_state == 3) ? 1 : 0);
      check("model_game_over", int'(game_over), (m_state == 5) ? 1 : 0);
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic tick_n(input int n);
    for (int i = 0; i < n; i++) begin
      tick = 1'b1; step(); tick = 1'b0; step();
    end
  endtask

  // Ends in PLAY after the death delay and the one-cycle respawn.
  task automatic finish_death();
    tick_n(DEATH_TICKS - 1);
    tick = 1'b1; step(); tick = 1'b0;
    check("death_end_respawn", int'(state), 3);
    check("death_end_frog_reset", int'(frog_reset), 1);
    step();
    check("death_end_play", int'(state), 1);
  endtask

  initial begin
    int exp_lives;

    // 1: reset and start
    step(); step();
    Reset = 1'b0;
    step();
    check("rst_state", int'(state), 0);
    check("rst_lives", int'(lives), 3);
    check("rst_speed", int'(speed), 0);
    check("rst_timer", int'(timer), 30);
    check("rst_frog_reset", int'(frog_reset), 0);
    start = 1'b1; step(); start = 1'b0;
    check("start_respawn", int'(state), 3);
    check("start_frog_reset", int'(frog_reset), 1);
    step();
    check("start_play", int'(state), 1);
    check("start_frog_reset_low", int'(frog_reset), 0);
    check("start_timer", int'(timer), 30);

    // 2: collision death
    collision = 1'b1; step(); collision = 1'b0;
    check("coll_dying", int'(state), 2);
    check("coll_lives", int'(lives), 2);
    finish_death();

    // 3: time-out death
    tick_n(ROUND_SECS * TICKS_PER_SEC - 1);
    check("timeout_timer_1", int'(timer), 1);
    tick = 1'b1; step(); tick = 1'b0;
    check("timeout_dying", int'(state), 2);
    check("timeout_timer_0", int'(timer), 0);
    check("timeout_lives", int'(lives), 1);
    finish_death();

    // 4: third death -> game over, restart
    collision = 1'b1; step(); collision = 1'b0;
    check("last_lives", int'(lives), 0);
    tick_n(DEATH_TICKS - 1);
    tick = 1'b1; step(); tick = 1'b0;
    check("go_state", int'(state), 5);
    check("go_flag", int'(game_over), 1);
    check("go_no_respawn", int'(frog_reset), 0);
    step();
    start = 1'b1; step(); start = 1'b0;
    check("go_to_idle", int'(state), 0);
    check("idle_go_low", int'(game_over), 0);
    step();
    check("idle_hold", int'(state), 0);
    start = 1'b1; step(); start = 1'b0;
    check("restart_lives", int'(lives), 3);
    check("restart_respawn", int'(state), 3);
    step();

    // 5: simultaneous events, sub-tick boundary, level-ups
    collision = 1'b1; all_home = 1'b1; home_event = 1'b1; step();
    collision = 1'b0; all_home = 1'b0; home_event = 1'b0;
    check("simul_dying", int'(state), 2);
    check("simul_speed", int'(speed), 0);
    finish_death();
    tick_n(TICKS_PER_SEC - 1);
    check("subtick_timer_30", int'(timer), 30);
    tick_n(1);
    check("subtick_timer_29", int'(timer), 29);
    home_event = 1'b1; step(); home_event = 1'b0;
    check("home_respawn", int'(state), 3);
    check("home_timer", int'(timer), 30);
    step();
    all_home = 1'b1; step(); all_home = 1'b0;
    check("lvl_state", int'(state), 4);
    step(); step();
    check("lvl_speed_1", int'(speed), 1);
    for (int i = 0; i < 9; i++) begin
      all_home = 1'b1; step(); all_home = 1'b0;
      step(); step();
    end
    check("lvl_speed_sat", int'(speed), 9);
`ifdef FROG_BONUS_LIFE_EN
    exp_lives = 7;
`else
    exp_lives = 2;
`endif
    check("lvl_lives", int'(lives), exp_lives);

    // 6: reset mid-DYING
    collision = 1'b1; step(); collision = 1'b0;
    check("mid_dying", int'(state), 2);
    tick_n(29);
    tick = 1'b1; Reset = 1'b1; step(); tick = 1'b0; Reset = 1'b0;
    check("abort_idle", int'(state), 0);
    check("abort_frog_reset", int'(frog_reset), 0);
    check("abort_lives", int'(lives), 3);
    step();
    check("abort_still_idle", int'(state), 0);
    check("abort_no_pulse", int'(frog_reset), 0);
    step(); step();

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
